// File: rtl/iiitb_bidicntr_mon.sv
// rtl/iiitb_bidicntr_mon.sv - sampling monitor for a 4-bit up/down counter stream
// Predicts each next count from the previous sample and its direction, and flags broken steps.
module iiitb_bidicntr_mon #(
  parameter int WIDTH  = 4,
  parameter int ERR_W  = 8,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic              ctrl,
  input  logic [WIDTH-1:0]  count,
  output logic              locked,
  output logic              dir,
  output logic [WIDTH-1:0]  expected,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WRAP_W-1:0] wrap_cnt
);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

  localparam logic [WIDTH-1:0]  CNT_ONE  = 1;
  localparam logic [WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [ERR_W-1:0]  ERR_ONE  = 1;
  localparam logic [WRAP_W-1:0] WRAP_ONE = 1;

  state_t             state, state_n;
  logic [WIDTH-1:0]   prev_count, prev_count_n;
  logic               prev_ctrl, prev_ctrl_n;
  logic [WIDTH-1:0]   pred;
  logic               hit;
  logic               wrap_step;

  logic               locked_n;
  logic               dir_n;
  logic [WIDTH-1:0]   expected_n;
  logic               err_pulse_n;
  logic [ERR_W-1:0]   err_cnt_n;
  logic [WRAP_W-1:0]  wrap_cnt_n;

  // Prediction is always from the previous sample and the ctrl captured with it.
  assign pred      = prev_ctrl ? (prev_count - CNT_ONE) : (prev_count + CNT_ONE);
  assign hit       = (count == pred);
  assign wrap_step = (!prev_ctrl && (prev_count == CNT_MAX)) ||
                     ( prev_ctrl && (prev_count == '0));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      prev_count <= '0;
      prev_ctrl  <= 1'b0;
      locked     <= 1'b0;
      dir        <= 1'b0;
      expected   <= '0;
      err_pulse  <= 1'b0;
      err_cnt    <= '0;
      wrap_cnt   <= '0;
    end else begin
      state      <= state_n;
      prev_count <= prev_count_n;
      prev_ctrl  <= prev_ctrl_n;
      locked     <= locked_n;
      dir        <= dir_n;
      expected   <= expected_n;
      err_pulse  <= err_pulse_n;
      err_cnt    <= err_cnt_n;
      wrap_cnt   <= wrap_cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    prev_count_n = prev_count;
    prev_ctrl_n  = prev_ctrl;
    locked_n     = locked;
    dir_n        = dir;
    expected_n   = expected;
    err_pulse_n  = 1'b0;
    err_cnt_n    = err_cnt;
    wrap_cnt_n   = wrap_cnt;

    if (valid) begin
      prev_count_n = count;
      prev_ctrl_n  = ctrl;
      expected_n   = ctrl ? (count - CNT_ONE) : (count + CNT_ONE);

      case (state)
        IDLE: begin
          state_n = ACQ;
        end
        ACQ: begin
          // A mismatch while acquiring is a resync, never an error.
          if (hit) begin
            state_n  = LOCKED;
            locked_n = 1'b1;
            dir_n    = prev_ctrl;
          end
        end
        LOCKED: begin
          if (hit) begin
            dir_n = prev_ctrl;
            if (wrap_step && (wrap_cnt != '1)) begin
              wrap_cnt_n = wrap_cnt + WRAP_ONE;
            end
          end else begin
            state_n     = ACQ;
            locked_n    = 1'b0;
            err_pulse_n = 1'b1;
            if (err_cnt != '1) begin
              err_cnt_n = err_cnt + ERR_ONE;
            end
          end
        end
        default: begin
          state_n  = IDLE;
          locked_n = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iiitb_bidicntr_mon.sv
// tb/tb_iiitb_bidicntr_mon.sv - self-checking bench for iiitb_bidicntr_mon
// A sample-history model checks every cycle; directed literals pin the model.
module tb_iiitb_bidicntr_mon;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid = 1'b0;
  logic       ctrl = 1'b0;
  logic [3:0] count = 4'd0;

  logic       locked, dir, err_pulse;
  logic [3:0] expected;
  logic [7:0] err_cnt, wrap_cnt;

  logic       s_locked, s_dir, s_err_pulse;
  logic [3:0] s_expected;
  logic [1:0] s_err_cnt;
  logic [7:0] s_wrap_cnt;

  int total = 0;
  int passed = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  iiitb_bidicntr_mon dut (
    .clk(clk), .reset(reset), .valid(valid), .ctrl(ctrl), .count(count),
    .locked(locked), .dir(dir), .expected(expected), .err_pulse(err_pulse),
    .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
  );

  iiitb_bidicntr_mon #(.WIDTH(4), .ERR_W(2), .WRAP_W(8)) dut_sat (
    .clk(clk), .reset(reset), .valid(valid), .ctrl(ctrl), .count(count),
    .locked(s_locked), .dir(s_dir), .expected(s_expected), .err_pulse(s_err_pulse),
    .err_cnt(s_err_cnt), .wrap_cnt(s_wrap_cnt)
  );

  // Model: locked after a sample iff it continued the previous sample's step;
  // an error is a broken step right after a continued one.
  bit have_prev, last_match, m_pulse, m_dir, hit;
  int prev_val, prev_dn, pred, m_exp, m_err, m_err2, m_wrap;

  always @(posedge clk) begin
    if (!reset) begin
      have_prev = 0; last_match = 0; m_pulse = 0; m_dir = 0;
      prev_val = 0; prev_dn = 0; m_exp = 0; m_err = 0; m_err2 = 0; m_wrap = 0;
    end else begin
      m_pulse = 0;
      if (valid) begin
        pred = prev_dn ? (prev_val + 15) % 16 : (prev_val + 1) % 16;
        hit  = have_prev && (int'(count) == pred);
        if (have_prev && !hit && last_match) begin
          m_pulse = 1;
          if (m_err < 255) m_err++;
          if (m_err2 < 3) m_err2++;
        end
        if (hit) begin
          m_dir = prev_dn[0];
          if (last_match && ((prev_val == 15 && prev_dn == 0) || (prev_val == 0 && prev_dn == 1)))
            if (m_wrap < 255) m_wrap++;
        end
        last_match = hit;
        have_prev  = 1;
        prev_val   = int'(count);
        prev_dn    = int'(ctrl);
        m_exp      = ctrl ? (int'(count) + 15) % 16 : (int'(count) + 1) % 16;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("locked", int'(locked), int'(last_match));
      chk("dir", int'(dir), int'(m_dir));
      chk("expected", int'(expected), m_exp);
      chk("err_pulse", int'(err_pulse), int'(m_pulse));
      chk("err_cnt", int'(err_cnt), m_err);
      chk("wrap_cnt", int'(wrap_cnt), m_wrap);
      chk("sat_locked", int'(s_locked), int'(last_match));
      chk("sat_err_pulse", int'(s_err_pulse), int'(m_pulse));
      chk("sat_err_cnt", int'(s_err_cnt), m_err2);
    end
  end

  task automatic drive(input bit v, input bit c, input int n);
    valid = v;
    ctrl  = c;
    count = 4'(n);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    drive(1'b1, 1'b0, 1);
    reset = 1'b1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_expected"}, int'(expected), 0);
    chk({tag, "_err_cnt"}, int'(err_cnt), 0);
    chk({tag, "_wrap_cnt"}, int'(wrap_cnt), 0);
    chk({tag, "_err_pulse"}, int'(err_pulse), 0);
    chk({tag, "_dir"}, int'(dir), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int v;
    int sat_exp[5];
    sat_exp = '{1, 2, 3, 3, 3};

    // reset held with toggling valid samples
    reset = 1'b0;
    drive(1'b1, 1'b0, 5);
    checking = 1'b1;
    all_zero("rst0");
    drive(1'b1, 1'b1, 10);
    all_zero("rst1");
    reset = 1'b1;
    drive(1'b0, 1'b0, 3);
    drive(1'b0, 1'b0, 7);
    all_zero("idle");

    // up run with wrap
    drive(1'b1, 1'b0, 13);
    chk("up13_locked", int'(locked), 0);
    chk("up13_expected", int'(expected), 14);
    drive(1'b1, 1'b0, 14);
    chk("up14_locked", int'(locked), 1);
    drive(1'b1, 1'b0, 15);
    chk("up15_expected", int'(expected), 0);
    drive(1'b1, 1'b0, 0);
    chk("up0_wrap", int'(wrap_cnt), 1);
    drive(1'b1, 1'b0, 1);
    chk("up1_err", int'(err_cnt), 0);
    chk("up1_dir", int'(dir), 0);

    // direction change and down wrap
    pulse_reset();
    drive(1'b1, 1'b0, 2);
    drive(1'b1, 1'b0, 3);
    drive(1'b1, 1'b1, 4);
    chk("dn4_dir", int'(dir), 0);
    chk("dn4_expected", int'(expected), 3);
    drive(1'b1, 1'b1, 3);
    chk("dn3_dir", int'(dir), 1);
    drive(1'b1, 1'b1, 2);
    drive(1'b1, 1'b1, 1);
    drive(1'b1, 1'b1, 0);
    chk("dn0_expected", int'(expected), 15);
    drive(1'b1, 1'b1, 15);
    chk("dn15_wrap", int'(wrap_cnt), 1);
    chk("dn15_err", int'(err_cnt), 0);

    // glitch then re-lock
    pulse_reset();
    drive(1'b1, 1'b0, 5);
    drive(1'b1, 1'b0, 6);
    chk("g6_locked", int'(locked), 1);
    drive(1'b1, 1'b0, 9);
    chk("g9_pulse", int'(err_pulse), 1);
    chk("g9_err", int'(err_cnt), 1);
    chk("g9_locked", int'(locked), 0);
    drive(1'b1, 1'b0, 10);
    chk("g10_pulse", int'(err_pulse), 0);
    chk("g10_locked", int'(locked), 1);
    drive(1'b1, 1'b0, 11);
    chk("g11_err", int'(err_cnt), 1);

    // a repeated value is a mismatch; idle cycles change nothing
    drive(1'b1, 1'b0, 11);
    chk("hold_pulse", int'(err_pulse), 1);
    drive(1'b0, 1'b0, 4);
    chk("hold_idle_pulse", int'(err_pulse), 0);
    chk("hold_idle_err", int'(err_cnt), 2);

    // reset mid-run
    pulse_reset();
    foreach (sat_exp[i]) v = i;
    drive(1'b1, 1'b0, 14); drive(1'b1, 1'b0, 15);
    drive(1'b1, 1'b0, 0);  drive(1'b1, 1'b0, 1);
    drive(1'b1, 1'b0, 5);  drive(1'b1, 1'b0, 6);
    drive(1'b1, 1'b0, 9);  drive(1'b1, 1'b0, 10);
    drive(1'b1, 1'b0, 13); drive(1'b1, 1'b0, 14);
    drive(1'b1, 1'b0, 15); drive(1'b1, 1'b0, 0);
    chk("mid_err", int'(err_cnt), 3);
    chk("mid_wrap", int'(wrap_cnt), 2);
    chk("mid_locked", int'(locked), 1);
    pulse_reset();
    all_zero("midrst");
    drive(1'b1, 1'b0, 3);
    chk("re3_locked", int'(locked), 0);
    drive(1'b1, 1'b0, 4);
    chk("re4_locked", int'(locked), 1);

    // saturation of the 2-bit error counter
    pulse_reset();
    drive(1'b1, 1'b0, 0);
    drive(1'b1, 1'b0, 1);
    v = 1;
    for (int g = 0; g < 5; g++) begin
      drive(1'b1, 1'b0, (v + 3) % 16);
      chk("sat_pulse", int'(s_err_pulse), 1);
      chk("sat_cnt", int'(s_err_cnt), sat_exp[g]);
      drive(1'b0, 1'b0, 0);
      drive(1'b1, 1'b0, (v + 4) % 16);
      chk("sat_relock", int'(s_locked), 1);
      v = (v + 4) % 16;
    end
    chk("sat_main_err", int'(err_cnt), 5);

    checking = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/iiitb_bidicntr_mon.md
# iiitb_bidicntr_mon

Sampling monitor for the 4-bit bidirectional (up/down) counter stream. It observes the counter's `count` output together with the `ctrl` direction input that drove it, predicts each next value, and flags any step that breaks the up/down sequence. It also counts wrap-arounds and errors. It sits beside the counter on the same clock as the read-side checker used in self-checking benches and on-chip health monitoring.

## Interface
- `WIDTH`, 4: width of the observed count
- `ERR_W`, 8: width of the saturating error counter
- `WRAP_W`, 8: width of the saturating wrap counter

- `clk`  in  1  single clock; all sampling and state updates on rising edge
- `reset`  in  1  synchronous, active-low reset
- `valid`  in  1  the `count`/`ctrl` pair is a sample this cycle
- `ctrl`  in  1  direction applied to the counter for the step that follows this sample: 0 = up, 1 = down
- `count`  in  WIDTH  observed counter value
- `locked`  out  1  monitor is tracking a consistent sequence
- `dir`  out  1  direction of the last matched step: 0 = up, 1 = down
- `expected`  out  WIDTH  predicted value of the next valid sample
- `err_pulse`  out  1  one-cycle pulse when a mismatch is detected
- `err_cnt`  out  ERR_W  saturating count of mismatches
- `wrap_cnt`  out  WRAP_W  saturating count of matched wrap-arounds

## Operation
- States: `IDLE`, `ACQ`, `LOCKED`.
- Reset (`reset`=0 at an edge):
  - state goes to `IDLE`
  - all outputs and internal `prev_count`/`prev_ctrl` registers go to 0
  - reset has priority over `valid`
- Prediction: `expected` = `prev_count` + 1 if `prev_ctrl`=0, else `prev_count` − 1, mod 2^WIDTH. Examples: 15+1 → 0, 0−1 → 15.
- `IDLE`: on `valid`, capture `count`/`ctrl` into `prev_*` and go to `ACQ`. `locked` stays 0.
- `ACQ`: on `valid`, compare `count` to `expected`.
  - Match: go to `LOCKED`, set `locked`=1, update `dir` = `prev_ctrl`.
  - Mismatch: stay in `ACQ` without error. A mismatch here is a resync, not a fault.
  - In both cases, capture the new sample into `prev_*`.
- `LOCKED`: on `valid`, compare `count` to `expected`.
  - Match: stay; update `dir`. If the step was 15→0 (up) or 0→15 (down), `wrap_cnt` += 1, saturating at all-ones.
  - Mismatch: `err_pulse`=1, `err_cnt` += 1 (saturating), `locked`=0, go to `ACQ`.
  - In both cases, capture the new sample into `prev_*`.
- Direction changes are legal at any sample. The prediction always uses the `ctrl` captured with the previous sample.
- `valid`=0 cycles: no state, counter, or `prev_*` change. `err_pulse` returns to 0.
- A counter hold (a repeated value) is a mismatch.
- Wraps are counted only on matched steps in `LOCKED`. The step that completes lock (`ACQ`→`LOCKED`) is not counted as a wrap.

## Timing
- All outputs are registered.
- Effects of a valid sample at edge N are visible after edge N: `err_pulse` and `err_cnt`, `locked`, `dir`, `wrap_cnt`, `expected`.
- `err_pulse` is high for exactly one cycle per mismatching sample. Back-to-back mismatching samples in `LOCKED` cannot occur, because the first mismatch drops the block to `ACQ`.
- Lock latency: 2 valid samples from `IDLE`. `locked` rises after the second consistent sample.
- Reset mid-operation:
  - takes effect at the next edge
  - clears counters and the error pulse
  - the sample present in that cycle is discarded
- Saturation: `err_cnt` and `wrap_cnt` hold at 2^W−1 and never roll over.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `valid`=1 and `count` toggling. Required: all outputs 0 and `locked`=0 throughout. After release with no `valid`, all outputs stay 0.
- Up run with wrap: `valid`=1 every cycle, `ctrl`=0, `count` 13,14,15,0,1.
  - `locked`=1 after the sample 14.
  - `wrap_cnt`=1 after the sample 0.
  - `err_cnt`=0 and `dir`=0 throughout.
- Direction change and down wrap: `count` 2,3,4 with `ctrl`=0, switching to `ctrl`=1 at the sample 4, then `count` 3,2,1,0,15.
  - No `err_pulse`.
  - `dir`=1 after the sample 3.
  - `wrap_cnt`=1 after the sample 15.
- Glitch: while locked and counting up at 6, present 9 instead of 7.
  - `err_pulse` for exactly 1 cycle, `err_cnt`=1, `locked`=0.
  - With the next samples 10, 11: `locked`=1 again after the sample 10, with no further errors.
- Reset mid-run: while locked with `err_cnt`=3 and `wrap_cnt`=2, assert `reset`=0 for 1 cycle. Required:
  - all outputs 0 the following cycle
  - state `IDLE`
  - re-lock takes 2 fresh valid samples
- Saturation: run with `ERR_W`=2 and inject 5 separate glitches, each followed by a re-lock. Required: `err_cnt` reads 1,2,3,3,3 and `err_pulse` fires all 5 times.
